// File: rtl/updown_mod_counter_if.sv
// updown_mod_counter_if: control and status bundle for updown_mod_counter.
//   master: drives clear/enable/up_dn/load/load_val/ovf_clr, observes status.
//   slave : the counter, consumes controls and drives
//           count/tc/sat/ovf/at_max/at_zero.
interface updown_mod_counter_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             enable;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             sat;
    logic             ovf;
    logic             at_max;
    logic             at_zero;

    modport master (
        output clear, enable, up_dn, load, load_val, ovf_clr,
        input  count, tc, sat, ovf, at_max, at_zero
    );

    modport slave (
        input  clear, enable, up_dn, load, load_val, ovf_clr,
        output count, tc, sat, ovf, at_max, at_zero
    );
endinterface

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: up/down counter over 0..MAX_VAL with wrap or saturate
// boundaries, parallel load, and terminal-count/saturation pulses. It also
// keeps a sticky overflow flag.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset (count=RESET_VAL, flags cleared)
//   bus     : slave side of updown_mod_counter_if
//             inputs : clear > load > enable priority, up_dn, load_val, ovf_clr
//             outputs: count, tc, sat, ovf (registered), at_max, at_zero (decoded)
module updown_mod_counter #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_VAL   = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE  = 1'b0,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input logic                clk,
    input logic                reset_n,
    updown_mod_counter_if.slave bus
);
    localparam longint unsigned FULL = (64'd1 << WIDTH) - 64'd1;
    localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST = RESET_VAL[WIDTH-1:0];

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_mod_counter: WIDTH must be 2..32");
    end
    if (MAX_VAL == 64'd0 || MAX_VAL > FULL) begin : g_bad_max
        $error("updown_mod_counter: MAX_VAL must be 1..2**WIDTH-1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_rst
        $error("updown_mod_counter: RESET_VAL must not exceed MAX_VAL");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d, sat_q, sat_d, ovf_q, ovf_d;
    logic             step, edge_hit, boundary;

    // The boundary compare precedes the add/subtract, so the +1/-1 path only
    // runs strictly inside 0..MAX and never relies on binary overflow.
    always_comb begin
        step     = bus.enable & ~bus.clear & ~bus.load;
        edge_hit = bus.up_dn ? (count_q == MAX) : (count_q == '0);
        boundary = step & edge_hit;
        tc_d     = boundary & ~SATURATE;
        sat_d    = boundary & SATURATE;
        count_d  = bus.clear ? RST
                 : bus.load  ? ((bus.load_val > MAX) ? MAX : bus.load_val)
                 : !step     ? count_q
                 : !edge_hit ? (bus.up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1))
                 : SATURATE  ? count_q
                 : bus.up_dn ? '0 : MAX;
        // A boundary event outranks ovf_clr so a simultaneous event is not lost.
        ovf_d    = bus.clear ? 1'b0 : boundary ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RST;
            tc_q    <= 1'b0;
            sat_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            sat_q   <= sat_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.sat     = sat_q;
    assign bus.ovf     = ovf_q;
    assign bus.at_max  = (count_q == MAX);
    assign bus.at_zero = (count_q == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter: drives a wrapping and a saturating counter (WIDTH=4,
// MAX_VAL=9) with identical stimulus and checks both against a range-based model.
module tb_updown_mod_counter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(4)) bw ();
    updown_mod_counter_if #(.WIDTH(4)) bs ();

    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RESET_VAL(0))
        dut_w (.clk(clk), .reset_n(reset_n), .bus(bw));
    updown_mod_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RESET_VAL(0))
        dut_s (.clk(clk), .reset_n(reset_n), .bus(bs));

    int total = 0;
    int bad = 0;
    int wc, wo, wt, ws;
    int sc, so, st, ss;

    // Count lives in 0..9; a step leaving that range is a boundary event.
    task automatic model(input bit cl, ld, en, up, oc, input int lv, input bit sm,
                         inout int c, inout int o, output int t, output int s);
        int n;
        t = 0;
        s = 0;
        if (cl) begin
            c = 0;
            o = 0;
        end else if (ld) begin
            c = (lv > 9) ? 9 : lv;
            if (oc) o = 0;
        end else begin
            if (en) begin
                n = up ? c + 1 : c - 1;
                if (n < 0 || n > 9) begin
                    if (sm) s = 1;
                    else begin
                        c = (n + 10) % 10;
                        t = 1;
                    end
                end else c = n;
            end
            if (oc) o = 0;
            if (t == 1 || s == 1) o = 1;
        end
    endtask

    task automatic drive(input bit cl, ld, en, up, oc, input int lv);
        bw.clear = cl; bw.load = ld; bw.enable = en; bw.up_dn = up; bw.ovf_clr = oc;
        bw.load_val = 4'(lv);
        bs.clear = cl; bs.load = ld; bs.enable = en; bs.up_dn = up; bs.ovf_clr = oc;
        bs.load_val = 4'(lv);
    endtask

    task automatic cycle(input bit cl, ld, en, up, oc, input int lv);
        drive(cl, ld, en, up, oc, lv);
        @(posedge clk);
        model(cl, ld, en, up, oc, lv, 1'b0, wc, wo, wt, ws);
        model(cl, ld, en, up, oc, lv, 1'b1, sc, so, st, ss);
        #1;
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        drive(0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #3;
        total += 4;
        if (bw.count !== 4'd0 || bs.count !== 4'd0) begin
            bad++; $display("FAIL reset count: got %0d/%0d want 0", bw.count, bs.count);
        end
        if ({bw.tc, bw.sat, bw.ovf, bs.tc, bs.sat, bs.ovf} !== 6'b0) begin
            bad++; $display("FAIL reset flags: got %b%b%b %b%b%b want 0", bw.tc, bw.sat, bw.ovf, bs.tc, bs.sat, bs.ovf);
        end
        if (bw.at_zero !== 1'b1 || bw.at_max !== 1'b0) begin
            bad++; $display("FAIL reset decode: got zero=%b max=%b want 1 0", bw.at_zero, bw.at_max);
        end
        if (bs.at_zero !== 1'b1 || bs.at_max !== 1'b0) begin
            bad++; $display("FAIL reset decode_s: got zero=%b max=%b want 1 0", bs.at_zero, bs.at_max);
        end
        wc = 0; wo = 0; wt = 0; ws = 0; sc = 0; so = 0; st = 0; ss = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_up_wrap;
        for (int i = 0; i < 11; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            total += 5;
            if (bw.count !== 4'(wc)) begin
                bad++; $display("FAIL up_wrap count[%0d]: got %0d want %0d", i, bw.count, wc);
            end
            if (bw.tc !== 1'(wt)) begin
                bad++; $display("FAIL up_wrap tc[%0d]: got %b want %0d", i, bw.tc, wt);
            end
            if (bw.ovf !== 1'(wo)) begin
                bad++; $display("FAIL up_wrap ovf[%0d]: got %b want %0d", i, bw.ovf, wo);
            end
            if (bw.at_max !== (wc == 9)) begin
                bad++; $display("FAIL up_wrap at_max[%0d]: got %b want %0d", i, bw.at_max, wc == 9);
            end
            if (bs.count !== 4'(sc) || bs.sat !== 1'(ss)) begin
                bad++; $display("FAIL up_wrap sat_dut[%0d]: got %0d/%b want %0d/%0d", i, bs.count, bs.sat, sc, ss);
            end
        end
    endtask

    task automatic test_down_wrap;
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 0, 0, 0);
            total += 3;
            if (bw.count !== 4'(9 - i) || bw.count !== 4'(wc)) begin
                bad++; $display("FAIL down count[%0d]: got %0d want %0d", i, bw.count, 9 - i);
            end
            if (bw.tc !== (i == 0)) begin
                bad++; $display("FAIL down tc[%0d]: got %b want %0d", i, bw.tc, i == 0);
            end
            if (bw.ovf !== 1'b1) begin
                bad++; $display("FAIL down ovf[%0d]: got %b want 1", i, bw.ovf);
            end
        end
        cycle(0, 0, 0, 0, 1, 0);
        total++;
        if (bw.ovf !== 1'b0 || bw.count !== 4'd7) begin
            bad++; $display("FAIL down ovf_clr: got ovf=%b count=%0d want 0 7", bw.ovf, bw.count);
        end
    endtask

    task automatic test_saturate;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 9);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 1, 0, 0);
            total += 2;
            if (bs.count !== 4'd9 || bs.sat !== 1'b1 || bs.tc !== 1'b0) begin
                bad++; $display("FAIL sat_up[%0d]: got count=%0d sat=%b tc=%b want 9 1 0", i, bs.count, bs.sat, bs.tc);
            end
            if (bs.ovf !== 1'b1 || bs.at_max !== 1'b1) begin
                bad++; $display("FAIL sat_up flags[%0d]: got ovf=%b at_max=%b want 1 1", i, bs.ovf, bs.at_max);
            end
        end
        cycle(0, 1, 0, 0, 0, 0);
        total++;
        if (bs.sat !== 1'b0) begin
            bad++; $display("FAIL sat_load_pulse: got sat=%b want 0", bs.sat);
        end
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 1, 0, 0, 0);
            total++;
            if (bs.count !== 4'd0 || bs.sat !== 1'b1 || bs.tc !== 1'b0 || bs.at_zero !== 1'b1) begin
                bad++; $display("FAIL sat_down[%0d]: got count=%0d sat=%b tc=%b want 0 1 0", i, bs.count, bs.sat, bs.tc);
            end
        end
        cycle(0, 0, 0, 0, 0, 0);
        total++;
        if (bs.sat !== 1'b0) begin
            bad++; $display("FAIL sat_idle: got sat=%b want 0", bs.sat);
        end
    endtask

    task automatic test_priority;
        cycle(0, 1, 0, 0, 0, 9);
        cycle(0, 0, 1, 1, 0, 0);
        cycle(1, 1, 1, 1, 0, 5);
        total += 3;
        if (bw.count !== 4'd0 || bw.ovf !== 1'b0 || bw.tc !== 1'b0) begin
            bad++; $display("FAIL prio_clear: got count=%0d ovf=%b tc=%b want 0 0 0", bw.count, bw.ovf, bw.tc);
        end
        cycle(0, 1, 1, 1, 0, 5);
        if (bw.count !== 4'd5 || bs.count !== 4'd5) begin
            bad++; $display("FAIL prio_load: got %0d/%0d want 5", bw.count, bs.count);
        end
        cycle(0, 1, 0, 0, 0, 15);
        if (bw.count !== 4'd9 || bs.count !== 4'd9) begin
            bad++; $display("FAIL load_clamp: got %0d/%0d want 9", bw.count, bs.count);
        end
    endtask

    task automatic test_ovf_race;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 9);
        cycle(0, 0, 1, 1, 1, 0);
        total += 2;
        if (bw.ovf !== 1'b1 || bw.tc !== 1'b1 || bw.count !== 4'd0) begin
            bad++; $display("FAIL race_wrap: got ovf=%b tc=%b count=%0d want 1 1 0", bw.ovf, bw.tc, bw.count);
        end
        if (bs.ovf !== 1'b1 || bs.sat !== 1'b1) begin
            bad++; $display("FAIL race_sat: got ovf=%b sat=%b want 1 1", bs.ovf, bs.sat);
        end
        cycle(0, 0, 0, 0, 1, 0);
        total++;
        if (bw.ovf !== 1'b0 || bs.ovf !== 1'b0 || bw.tc !== 1'b0) begin
            bad++; $display("FAIL race_clr: got ovf=%b/%b tc=%b want 0 0 0", bw.ovf, bs.ovf, bw.tc);
        end
    endtask

    task automatic test_async_reset;
        cycle(0, 1, 0, 0, 0, 9);
        cycle(0, 0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 5);
        cycle(0, 0, 1, 1, 0, 0);
        total++;
        if (bw.count !== 4'd6 || bw.ovf !== 1'b1 || bs.ovf !== 1'b1) begin
            bad++; $display("FAIL areset_pre: got count=%0d ovf=%b/%b want 6 1 1", bw.count, bw.ovf, bs.ovf);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total += 2;
        if (bw.count !== 4'd0 || bs.count !== 4'd0) begin
            bad++; $display("FAIL areset_count: got %0d/%0d want 0", bw.count, bs.count);
        end
        if ({bw.tc, bw.sat, bw.ovf, bs.tc, bs.sat, bs.ovf} !== 6'b0) begin
            bad++; $display("FAIL areset_flags: got %b%b%b %b%b%b want 0", bw.tc, bw.sat, bw.ovf, bs.tc, bs.sat, bs.ovf);
        end
        wc = 0; wo = 0; sc = 0; so = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1, 0, 0);
        total++;
        if (bw.count !== 4'd3 || bs.count !== 4'd3) begin
            bad++; $display("FAIL areset_resume: got %0d/%0d want 3", bw.count, bs.count);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom_range(0, 15));
            total += 4;
            if (bw.count !== 4'(wc) || bs.count !== 4'(sc)) begin
                bad++; $display("FAIL rand count[%0d]: got %0d/%0d want %0d/%0d", i, bw.count, bs.count, wc, sc);
            end
            if (bw.tc !== 1'(wt) || bw.sat !== 1'b0 || bs.tc !== 1'b0 || bs.sat !== 1'(ss)) begin
                bad++; $display("FAIL rand pulse[%0d]: got tc=%b/%b sat=%b/%b want %0d/0 0/%0d", i, bw.tc, bs.tc, bw.sat, bs.sat, wt, ss);
            end
            if (bw.ovf !== 1'(wo) || bs.ovf !== 1'(so)) begin
                bad++; $display("FAIL rand ovf[%0d]: got %b/%b want %0d/%0d", i, bw.ovf, bs.ovf, wo, so);
            end
            if (bw.at_max !== (wc == 9) || bw.at_zero !== (wc == 0) ||
                bs.at_max !== (sc == 9) || bs.at_zero !== (sc == 0)) begin
                bad++; $display("FAIL rand decode[%0d]: got %b%b/%b%b for %0d/%0d", i, bw.at_max, bw.at_zero, bs.at_max, bs.at_zero, wc, sc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_saturate();
        test_priority();
        test_ovf_race();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
